key_ascii_encoder: RTL and testbench

Sequential successor to the combinational one-hot key decoder. Samples the 27-bit one-hot key vector every clock, detects new presses, tracks a Caps Lock toggle, converts letter presses to upper/lower-case ASCII and queues them in a parametrised FIFO. The FIFO drains through a valid/ready port to the text/display consumer. The block sits between the keyboard front-end and that consumer.

---
 rtl/key_ascii_encoder_pkg.sv | 37 +++
 rtl/key_ascii_encoder_if.sv | 17 +
 rtl/key_ascii_encoder_sync_fifo.sv | 62 ++++++
 rtl/key_ascii_encoder.sv | 132 +++++++++++++
 tb/tb_key_ascii_encoder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/key_ascii_encoder_pkg.sv
// key_enc_pkg: shared constants, types and the letter-to-ASCII helper for
// the key_ascii_encoder block.
//   NUM_KEYS / KEY_CAPS_BIT / NUM_LETTERS : layout of the one-hot key vector
//   ASCII_LOWER_A / ASCII_UPPER_A         : base codes for lower/upper case
//   ascii_t                               : 7-bit character type
//   rpt_phase_t                           : auto-repeat timing phase
package key_enc_pkg;

  typedef logic [6:0] ascii_t;

  localparam int unsigned NUM_KEYS     = 27;
  localparam int unsigned KEY_CAPS_BIT = 26;
  localparam int unsigned NUM_LETTERS  = 26;

  localparam ascii_t ASCII_LOWER_A = 7'd97;
  localparam ascii_t ASCII_UPPER_A = 7'd65;

  // Waiting for the initial repeat delay, or repeating at the period rate.
  typedef enum logic {
    RPT_DELAY,
    RPT_PERIOD
  } rpt_phase_t;

  // Bit 25 is 'a', bit 0 is 'z'; caller guarantees exactly one letter bit set.
  function automatic ascii_t letter_code(input logic caps,
                                         input logic [NUM_LETTERS-1:0] letters);
    ascii_t base;
    ascii_t off;
    base = caps ? ASCII_UPPER_A : ASCII_LOWER_A;
    off  = '0;
    for (int unsigned i = 0; i < NUM_LETTERS; i++) begin
      if (letters[i]) off = 7'(NUM_LETTERS - 1 - i);
    end
    return base + off;
  endfunction

endpackage

// File: rtl/key_ascii_encoder_if.sv
// key_ascii_encoder_if: character output stream from the encoder to the
// text/display consumer.
//   out_char  : ASCII of the queue head, 0 when empty
//   out_valid : queue not empty
//   out_ready : consumer accepts out_char when out_valid && out_ready
// master = encoder side, slave = consumer side.
interface key_ascii_encoder_if;
  import key_enc_pkg::*;

  ascii_t out_char;
  logic   out_valid;
  logic   out_ready;

  modport master (output out_char, output out_valid, input out_ready);
  modport slave  (input out_char, input out_valid, output out_ready);

endinterface

// File: rtl/key_ascii_encoder_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered drop indication.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write request and data
//   pop        : read request (ignored when empty)
//   rdata      : head entry, 0 when empty
//   empty/full : occupancy flags
//   overflow   : one-cycle pulse after an edge where a push was dropped
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      overflow <= push && full && !do_pop;
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_ascii_encoder.sv
// key_ascii_encoder: samples the one-hot key vector, detects new presses,
// tracks Caps Lock, converts letters to ASCII and queues them for the
// consumer.
//   clk, rst_n : clock, asynchronous active-low reset
//   key_down   : bit 26 = Caps, bit 25 = 'a' ... bit 0 = 'z'
//   out_if     : character stream (out_char / out_valid / out_ready)
//   caps_on    : current Caps Lock state
//   overflow   : one-cycle pulse when a character is dropped
// Build option: KEY_AUTOREPEAT_EN enables auto-repeat of a held letter
// after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
module key_ascii_encoder
  import key_enc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_down,
  key_ascii_encoder_if.master out_if,
  output logic                caps_on,
  output logic                overflow
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("key_ascii_encoder: illegal parameter value");
  end

  logic [NUM_KEYS-1:0] key_q;
  logic                legal;
  logic                new_key;
  logic                caps_press;
  logic                letter_press;
  logic                rpt_fire;
  logic                push;
  logic                fifo_empty;
  logic                fifo_full;
  ascii_t              code;

  assign legal        = $onehot(key_down);
  assign new_key      = (key_down != key_q);
  assign caps_press   = legal && new_key && key_down[KEY_CAPS_BIT];
  assign letter_press = legal && new_key && !key_down[KEY_CAPS_BIT];
  // caps_on here is the pre-edge value, so a letter pressed together with
  // a Caps toggle edge is never possible (one-hot) and repeats use current.
  assign code         = letter_code(caps_on, key_down[NUM_LETTERS-1:0]);
  assign push         = letter_press || rpt_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= '0;
      caps_on <= 1'b0;
    end else begin
      key_q <= key_down;
      if (caps_press) caps_on <= !caps_on;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                   : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  rpt_phase_t       rpt_state;
  rpt_phase_t       rpt_state_nxt;
  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_cnt_nxt;
  logic [RPT_W-1:0] rpt_limit;
  logic             held_letter;

  assign held_letter = legal && !new_key && !key_down[KEY_CAPS_BIT];
  assign rpt_limit   = (rpt_state == RPT_DELAY) ? RPT_W'(REPEAT_DELAY - 1)
                                                : RPT_W'(REPEAT_PERIOD - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_state <= RPT_DELAY;
      rpt_cnt   <= '0;
    end else begin
      rpt_state <= rpt_state_nxt;
      rpt_cnt   <= rpt_cnt_nxt;
    end
  end

  always_comb begin
    rpt_state_nxt = rpt_state;
    rpt_cnt_nxt   = rpt_cnt;
    rpt_fire      = 1'b0;
    if (letter_press) begin
      rpt_state_nxt = RPT_DELAY;
      rpt_cnt_nxt   = '0;
    end else if (held_letter) begin
      if (rpt_cnt == rpt_limit) begin
        rpt_fire      = 1'b1;
        rpt_state_nxt = RPT_PERIOD;
        rpt_cnt_nxt   = '0;
      end else begin
        rpt_cnt_nxt = rpt_cnt + 1'b1;
      end
    end else begin
      // release, illegal vector or Caps held
      rpt_state_nxt = RPT_DELAY;
      rpt_cnt_nxt   = '0;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  sync_fifo #(
    .WIDTH ($bits(ascii_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (out_if.out_ready),
    .wdata    (code),
    .rdata    (out_if.out_char),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .overflow (overflow)
  );

  assign out_if.out_valid = !fifo_empty;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_key_ascii_encoder.sv
module tb_key_ascii_encoder;
  import key_enc_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned RD    = 8;
  localparam int unsigned RP    = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NUM_KEYS-1:0] key_down = '0;
  logic                caps_on;
  logic                overflow;

  key_ascii_encoder_if bus ();

  key_ascii_encoder #(
    .FIFO_DEPTH    (DEPTH),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_down (key_down),
    .out_if   (bus.master),
    .caps_on  (caps_on),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_KEYS-1:0] k(input int unsigned i);
    logic [NUM_KEYS-1:0] one;
    one = 1;
    return one << i;
  endfunction

  // ---------------- behavioural model ----------------
  string               alpha = "abcdefghijklmnopqrstuvwxyz";
  byte unsigned        mq[$];
  logic [NUM_KEYS-1:0] m_prev;
  bit                  m_caps;
  bit                  m_ovf;
  int unsigned         m_held;

  function automatic byte unsigned char_of(input logic [NUM_KEYS-1:0] kd, input bit caps);
    byte unsigned c;
    c = 0;
    for (int i = 0; i < 26; i++) if (kd[i]) c = alpha[25 - i];
    if (caps) c = c - 8'd32;
    return c;
  endfunction

  always @(posedge clk) begin
    logic [NUM_KEYS-1:0] kd;
    bit                  legal;
    bit                  press;
    bit                  push;
    byte unsigned        pc;
    kd = key_down;
    if (!rst_n) begin
      mq.delete();
      m_prev = '0;
      m_caps = 0;
      m_ovf  = 0;
      m_held = 0;
    end else begin
      legal = ($countones(kd) == 1);
      press = legal && (kd != m_prev);
      push  = 0;
      pc    = char_of(kd, m_caps);
      if (press && !kd[KEY_CAPS_BIT]) push = 1;
      if (press && kd[KEY_CAPS_BIT]) m_caps = !m_caps;
`ifdef KEY_AUTOREPEAT_EN
      if (press) m_held = 0;
      else if (legal && !kd[KEY_CAPS_BIT] && kd == m_prev) begin
        m_held++;
        if (m_held == RD || (m_held > RD && (m_held - RD) % RP == 0)) push = 1;
      end else m_held = 0;
`endif
      if (mq.size() != 0 && bus.out_ready) void'(mq.pop_front());
      m_ovf = 0;
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back(pc);
        else m_ovf = 1;
      end
      m_prev = kd;
    end
    #1;
    check("model_out_valid", bus.out_valid, (mq.size() != 0) ? 1 : 0);
    check("model_out_char", bus.out_char, (mq.size() != 0) ? mq[0] : 0);
    check("model_caps_on", caps_on, m_caps);
    check("model_overflow", overflow, m_ovf);
  end

  // ---------------- stimulus + literal pins ----------------
  task automatic step(input logic [NUM_KEYS-1:0] kd, input logic rdy);
    @(negedge clk);
    key_down      = kd;
    bus.out_ready = rdy;
    @(posedge clk);
    #2;
  endtask

  int unsigned exp_drain[4] = '{99, 100, 101, 103};

  initial begin
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", bus.out_valid, 0);
    check("reset_char", bus.out_char, 0);
    check("reset_caps", caps_on, 0);
    check("reset_ovf", overflow, 0);
    rst_n = 1'b1;

    // single 'a'
    step(k(25), 1);
    check("a_valid", bus.out_valid, 1);
    check("a_char", bus.out_char, 97);
    step('0, 1);
    check("a_popped", bus.out_valid, 0);

    // Caps then 'z' -> 'Z', second Caps clears
    step(k(26), 1);
    check("caps_set", caps_on, 1);
    step('0, 1);
    step(k(0), 1);
    check("upper_z", bus.out_char, 90);
    step('0, 1);
    step(k(26), 1);
    check("caps_clr", caps_on, 0);
    step('0, 1);

    // b..f into depth-4 queue, 'f' dropped
    for (int unsigned i = 0; i < 5; i++) begin
      step(k(24 - i), 0);
      check("fill_ovf", overflow, (i == 4) ? 1 : 0);
      step('0, 0);
      check("fill_ovf_end", overflow, 0);
    end
    check("full_head", bus.out_char, 98);
    // full + push + pop
    step(k(19), 1);
    check("g_no_ovf", overflow, 0);
    step('0, 0);
    for (int j = 0; j < 4; j++) begin
      check("drain_char", bus.out_char, exp_drain[j]);
      step('0, 1);
    end
    check("drain_empty", bus.out_valid, 0);

    // illegal vectors leave caps and queue alone
    step(k(26), 0);
    step('0, 0);
    step(k(25) | k(24), 0);
    step('0, 0);
    check("multi_no_push", bus.out_valid, 0);
    check("multi_caps", caps_on, 1);
    step(k(26), 0);
    step('0, 0);

    // hold 'p'
    repeat (100) step(k(10), 0);
    step('0, 0);
    check("hold_p_char", bus.out_char, 112);
`ifndef KEY_AUTOREPEAT_EN
    step('0, 1);
    check("hold_p_single", bus.out_valid, 0);
`else
    repeat (DEPTH) step('0, 1);
`endif

    // hold 'a' 20 cycles, then reset mid-hold
    repeat (20) step(k(25), 0);
    check("hold_a_head", bus.out_char, 97);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_valid", bus.out_valid, 0);
    check("midreset_char", bus.out_char, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("post_reset_press", bus.out_char, 97);
    repeat (DEPTH + 1) step('0, 1);

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      logic [NUM_KEYS-1:0] kd;
      int unsigned r;
      kd = key_down;
      r  = $urandom_range(0, 9);
      if (r < 2) kd = '0;
      else if (r < 6) kd = k($urandom_range(0, 26));
      else if (r == 6) kd = NUM_KEYS'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      step(kd, ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
    end

    step('0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
